// File: rtl/alubarrel_seq_pkg.sv
// rtl/alubarrel_seq_pkg.sv - shared types and opcode constants for the ALUBarrel sequencer
package alubarrel_seq_pkg;

  typedef enum logic [1:0] {IDLE, READ, EXEC, WB} state_e;

  // Encodings 11..15 all mean "never"; the top clamps them to COND_NV.
  typedef enum logic [3:0] {
    COND_AL, COND_EQ, COND_NE, COND_HS, COND_LO, COND_HI,
    COND_LS, COND_GE, COND_LT, COND_GT, COND_LE, COND_NV
  } cond_e;

  localparam logic [1:0] ALU_ADD = 2'd0;
  localparam logic [1:0] ALU_SUB = 2'd1;
  localparam logic [1:0] ALU_AND = 2'd2;
  localparam logic [1:0] ALU_OR  = 2'd3;

  localparam logic [1:0] SH_LSL = 2'd0;
  localparam logic [1:0] SH_LSR = 2'd1;
  localparam logic [1:0] SH_ASR = 2'd2;
  localparam logic [1:0] SH_ROR = 2'd3;

endpackage

// File: rtl/ALUBarrel.sv
// rtl/ALUBarrel.sv - 8-bit ALU whose second operand passes through a barrel shifter
module ALUBarrel
  import alubarrel_seq_pkg::*;
(
  input  logic [7:0] a_i,
  input  logic [7:0] b_i,
  input  logic [2:0] amt_i,
  input  logic [1:0] opbarrel_i,
  input  logic [1:0] aluctl_i,
  output logic [7:0] y_o,
  output logic [3:0] nzcv_o
);

  logic [7:0] sh;
  logic [8:0] sum;
  logic [7:0] y;
  logic       c, v;

  always_comb begin
    case (opbarrel_i)
      SH_LSL:  sh = b_i << amt_i;
      SH_LSR:  sh = b_i >> amt_i;
      SH_ASR:  sh = $unsigned($signed(b_i) >>> amt_i);
      default: sh = 8'({b_i, b_i} >> amt_i);
    endcase

    // SUB is a + ~b + 1, so the carry out is 1 exactly when no borrow occurs.
    // Logic ops clear both C and V.
    sum = 9'd0;
    y   = 8'd0;
    c   = 1'b0;
    v   = 1'b0;
    case (aluctl_i)
      ALU_ADD: begin
        sum = {1'b0, a_i} + {1'b0, sh};
        y   = sum[7:0];
        c   = sum[8];
        v   = (a_i[7] == sh[7]) && (y[7] != a_i[7]);
      end
      ALU_SUB: begin
        sum = {1'b0, a_i} + {1'b0, ~sh} + 9'd1;
        y   = sum[7:0];
        c   = sum[8];
        v   = (a_i[7] != sh[7]) && (y[7] != a_i[7]);
      end
      ALU_AND: y = a_i & sh;
      default: y = a_i | sh;
    endcase

    y_o    = y;
    nzcv_o = {y[7], (y == 8'd0), c, v};
  end

endmodule

// File: rtl/seq_cond_check.sv
// rtl/seq_cond_check.sv - ARM-style condition evaluation against committed NZCV
module seq_cond_check
  import alubarrel_seq_pkg::*;
(
  input  cond_e      cond_i,
  input  logic [3:0] nzcv_i,
  output logic       pass_o
);

  logic n, z, c, v;

  always_comb begin
    {n, z, c, v} = nzcv_i;
    pass_o = 1'b0;
    case (cond_i)
      COND_AL: pass_o = 1'b1;
      COND_EQ: pass_o = z;
      COND_NE: pass_o = !z;
      COND_HS: pass_o = c;
      COND_LO: pass_o = !c;
      COND_HI: pass_o = c && !z;
      COND_LS: pass_o = !c || z;
      COND_GE: pass_o = (n == v);
      COND_LT: pass_o = (n != v);
      COND_GT: pass_o = !z && (n == v);
      COND_LE: pass_o = z || (n != v);
      default: pass_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/alubarrel_seq.sv
// rtl/alubarrel_seq.sv - command sequencer: register file, NZCV flags, READ/EXEC/WB around ALUBarrel
module alubarrel_seq
  import alubarrel_seq_pkg::*;
#(
  parameter  int NREGS = 4,
  localparam int RA    = (NREGS > 1) ? $clog2(NREGS) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic          cmd_load,
  input  logic [7:0]    cmd_imm,
  input  logic [RA-1:0] cmd_rd,
  input  logic [RA-1:0] cmd_rn,
  input  logic [RA-1:0] cmd_rm,
  input  logic [2:0]    cmd_amt,
  input  logic [1:0]    cmd_opbarrel,
  input  logic [1:0]    cmd_aluctl,
  input  logic          cmd_we,
  input  logic          cmd_setflags,
  input  logic [3:0]    cmd_cond,
  output logic          done,
  output logic [7:0]    result,
  output logic          cond_pass,
  output logic [3:0]    flags,
  output logic          busy,
  input  logic [RA-1:0] dbg_addr,
  output logic [7:0]    dbg_data
);

  state_e        state_q;
  logic          load_q, we_q, setflags_q;
  logic [7:0]    imm_q;
  logic [RA-1:0] rd_q, rn_q, rm_q;
  logic [2:0]    amt_q;
  logic [1:0]    opbarrel_q, aluctl_q;
  logic [3:0]    cond_q;
  logic [7:0]    opa_q, opb_q;
  logic [7:0]    result_q;
  logic [3:0]    nzcv_q, flags_q;
  logic          pass_q, done_q;
  logic [7:0]    regs_q [NREGS];

  logic [7:0]    alu_y;
  logic [3:0]    alu_nzcv;
  logic          pass_d;
  cond_e         cond_sel;

  // Indices past NREGS read as zero (only reachable when NREGS is not a power of two).
  function automatic logic [7:0] read_reg(input logic [RA-1:0] idx);
    return (int'(idx) < NREGS) ? regs_q[idx] : 8'd0;
  endfunction

  assign cond_sel = (cond_q > 4'd10) ? COND_NV : cond_e'(cond_q);

  ALUBarrel u_alu (
    .a_i        (opa_q),
    .b_i        (opb_q),
    .amt_i      (amt_q),
    .opbarrel_i (opbarrel_q),
    .aluctl_i   (aluctl_q),
    .y_o        (alu_y),
    .nzcv_o     (alu_nzcv)
  );

  seq_cond_check u_cond (
    .cond_i (cond_sel),
    .nzcv_i (flags_q),
    .pass_o (pass_d)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      load_q     <= 1'b0;
      we_q       <= 1'b0;
      setflags_q <= 1'b0;
      imm_q      <= 8'd0;
      rd_q       <= '0;
      rn_q       <= '0;
      rm_q       <= '0;
      amt_q      <= 3'd0;
      opbarrel_q <= 2'd0;
      aluctl_q   <= 2'd0;
      cond_q     <= 4'd0;
      opa_q      <= 8'd0;
      opb_q      <= 8'd0;
      result_q   <= 8'd0;
      nzcv_q     <= 4'd0;
      flags_q    <= 4'd0;
      pass_q     <= 1'b0;
      done_q     <= 1'b0;
      for (int i = 0; i < NREGS; i++) regs_q[i] <= 8'd0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: if (cmd_valid) begin
          load_q     <= cmd_load;
          imm_q      <= cmd_imm;
          rd_q       <= cmd_rd;
          rn_q       <= cmd_rn;
          rm_q       <= cmd_rm;
          amt_q      <= cmd_amt;
          opbarrel_q <= cmd_opbarrel;
          aluctl_q   <= cmd_aluctl;
          we_q       <= cmd_we;
          setflags_q <= cmd_setflags;
          cond_q     <= cmd_cond;
          state_q    <= READ;
        end
        READ: begin
          opa_q   <= read_reg(rn_q);
          opb_q   <= read_reg(rm_q);
          state_q <= EXEC;
        end
        EXEC: begin
          result_q <= load_q ? imm_q : alu_y;
          nzcv_q   <= alu_nzcv;
          pass_q   <= pass_d;
          done_q   <= 1'b1;
          state_q  <= WB;
        end
        WB: begin
          if (pass_q && we_q && (int'(rd_q) < NREGS)) regs_q[rd_q] <= result_q;
          if (pass_q && setflags_q && !load_q) flags_q <= nzcv_q;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign cmd_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign result    = result_q;
  assign cond_pass = pass_q;
  assign flags     = flags_q;
  assign dbg_data  = read_reg(dbg_addr);

endmodule

// File: tb/tb_alubarrel_seq.sv
// tb/tb_alubarrel_seq.sv - directed and random checks of alubarrel_seq against an arithmetic model
module tb_alubarrel_seq;

  localparam int NREGS = 4;
  localparam int RA    = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          cmd_valid, cmd_ready, cmd_load, cmd_we, cmd_setflags;
  logic [7:0]    cmd_imm;
  logic [RA-1:0] cmd_rd, cmd_rn, cmd_rm, dbg_addr;
  logic [2:0]    cmd_amt;
  logic [1:0]    cmd_opbarrel, cmd_aluctl;
  logic [3:0]    cmd_cond;
  logic          done, cond_pass, busy;
  logic [7:0]    result, dbg_data;
  logic [3:0]    flags;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          mregs [NREGS];
  logic [3:0]  mflags;

  always #10 clk = ~clk;

  alubarrel_seq #(.NREGS(NREGS)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_load(cmd_load), .cmd_imm(cmd_imm), .cmd_rd(cmd_rd), .cmd_rn(cmd_rn),
    .cmd_rm(cmd_rm), .cmd_amt(cmd_amt), .cmd_opbarrel(cmd_opbarrel),
    .cmd_aluctl(cmd_aluctl), .cmd_we(cmd_we), .cmd_setflags(cmd_setflags),
    .cmd_cond(cmd_cond), .done(done), .result(result), .cond_pass(cond_pass),
    .flags(flags), .busy(busy), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int shval(input int b, input int amt, input int op);
    int sb;
    case (op)
      0: return (b << amt) % 256;
      1: return b >> amt;
      2: begin sb = (b >= 128) ? b - 256 : b; return (sb >>> amt) & 255; end
      default: return ((b >> amt) | (b << (8 - amt))) & 255;
    endcase
  endfunction

  function automatic void alu_model(input int a, input int b, input int op,
                                    output int y, output logic [3:0] f);
    int s, sa, sb, sv;
    logic c, v;
    sa = (a >= 128) ? a - 256 : a;
    sb = (b >= 128) ? b - 256 : b;
    c = 1'b0;
    v = 1'b0;
    case (op)
      0: begin s = a + b; sv = sa + sb; c = (s > 255); v = (sv > 127) || (sv < -128); end
      1: begin s = a - b; sv = sa - sb; c = (a >= b);  v = (sv > 127) || (sv < -128); end
      2: s = a & b;
      default: s = a | b;
    endcase
    y = s & 255;
    f = {(y >= 128), (y == 0), c, v};
  endfunction

  function automatic logic cond_model(input int cond, input logic [3:0] f);
    logic n, z, c, v;
    {n, z, c, v} = f;
    case (cond)
      0: return 1'b1;
      1: return z;
      2: return !z;
      3: return c;
      4: return !c;
      5: return c && !z;
      6: return !c || z;
      7: return n == v;
      8: return n != v;
      9: return !z && (n == v);
      10: return z || (n != v);
      default: return 1'b0;
    endcase
  endfunction

  task automatic check_regs(input string tag);
    for (int i = 0; i < NREGS; i++) begin
      dbg_addr = RA'(i);
      #1;
      check(tag, dbg_data, mregs[i]);
    end
  endtask

  task automatic scramble();
    cmd_load = 1'($urandom);     cmd_imm = 8'($urandom);
    cmd_rd = RA'($urandom);      cmd_rn = RA'($urandom);       cmd_rm = RA'($urandom);
    cmd_amt = 3'($urandom);      cmd_opbarrel = 2'($urandom);  cmd_aluctl = 2'($urandom);
    cmd_we = 1'($urandom);       cmd_setflags = 1'($urandom);  cmd_cond = 4'($urandom);
  endtask

  task automatic drive(input logic ld, input logic [7:0] imm, input int rd, input int rn,
                       input int rm, input int amt, input int opb, input int alu,
                       input logic we, input logic sf, input int cond);
    cmd_load = ld;               cmd_imm = imm;
    cmd_rd = RA'(rd);            cmd_rn = RA'(rn);             cmd_rm = RA'(rm);
    cmd_amt = 3'(amt);           cmd_opbarrel = 2'(opb);       cmd_aluctl = 2'(alu);
    cmd_we = we;                 cmd_setflags = sf;            cmd_cond = 4'(cond);
  endtask

  task automatic run_cmd(input logic ld, input logic [7:0] imm, input int rd, input int rn,
                         input int rm, input int amt, input int opb, input int alu,
                         input logic we, input logic sf, input int cond,
                         output logic [7:0] res_o, output logic pass_o);
    int y;
    logic [3:0] nf;
    logic p;
    alu_model(mregs[rn], shval(mregs[rm], amt, opb), alu, y, nf);
    if (ld) y = imm;
    p = cond_model(cond, mflags);

    @(negedge clk);
    check("idle_ready", cmd_ready, 1);
    drive(ld, imm, rd, rn, rm, amt, opb, alu, we, sf, cond);
    cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    scramble();
    check("read_busy", busy, 1);
    check("read_ready", cmd_ready, 0);
    check("read_done", done, 0);
    @(posedge clk); #1;
    check("exec_done", done, 0);
    @(posedge clk); #1;
    check("wb_done", done, 1);
    check("wb_result", result, y);
    check("wb_pass", cond_pass, p);
    res_o  = result;
    pass_o = cond_pass;
    if (p && we) mregs[rd] = y;
    if (p && sf && !ld) mflags = nf;
    @(posedge clk); #1;
    check("commit_done", done, 0);
    check("commit_flags", flags, mflags);
    check("commit_ready", cmd_ready, 1);
    check_regs("commit_reg");
  endtask

  // Loads carry setflags=1 so that every load also shows flags are left alone.
  task automatic do_load(input int rd, input logic [7:0] imm);
    logic [7:0] r;
    logic p;
    run_cmd(1'b1, imm, rd, 0, 0, 0, 0, 0, 1'b1, 1'b1, 0, r, p);
  endtask

  task automatic do_op(input int rd, input int rn, input int rm, input int amt, input int opb,
                       input int alu, input logic sf, input int cond,
                       output logic [7:0] r, output logic p);
    run_cmd(1'b0, 8'd0, rd, rn, rm, amt, opb, alu, 1'b1, sf, cond, r, p);
  endtask

  task automatic rd_dbg(input int i, output logic [7:0] v);
    dbg_addr = RA'(i);
    #1;
    v = dbg_data;
  endtask

  initial begin
    logic [7:0] r, rv;
    logic p;
    int nacc, ndone, ndouble;
    int acc_e [4];
    logic prev_done;

    reset = 1'b1;
    cmd_valid = 1'b0;
    dbg_addr = '0;
    drive(1'b0, 8'd0, 0, 0, 0, 0, 0, 0, 1'b0, 1'b0, 0);
    for (int i = 0; i < NREGS; i++) mregs[i] = 0;
    mflags = 4'd0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    check("rst_done", done, 0);
    check("rst_result", result, 0);
    check("rst_pass", cond_pass, 0);
    check("rst_flags", flags, 0);
    check("rst_busy", busy, 0);
    check("rst_ready", cmd_ready, 1);
    check_regs("rst_reg");

    // Basic SUB with flags
    do_load(1, 8'h05);
    do_load(2, 8'h03);
    do_op(0, 1, 2, 0, 0, 1, 1'b1, 0, r, p);
    check("tp1_result", r, 8'h02);
    check("tp1_flags", flags, 4'b0010);
    rd_dbg(0, rv);
    check("tp1_r0", rv, 8'h02);

    do_op(3, 2, 1, 0, 0, 1, 1'b1, 0, r, p);
    check("tp2_result", r, 8'hFE);
    check("tp2_flags", flags, 4'b1000);
    do_op(3, 1, 2, 0, 0, 0, 1'b1, 3, r, p);
    check("tp2_hs_pass", p, 0);
    rd_dbg(3, rv);
    check("tp2_r3_kept", rv, 8'hFE);
    check("tp2_flags_kept", flags, 4'b1000);

    do_load(1, 8'h7F);
    do_load(2, 8'h01);
    do_op(0, 1, 2, 0, 0, 0, 1'b1, 0, r, p);
    check("tp3_result", r, 8'h80);
    check("tp3_flags", flags, 4'b1001);
    do_op(3, 1, 2, 0, 0, 0, 1'b0, 8, r, p);
    check("tp3_lt_pass", p, 0);
    do_op(3, 1, 2, 0, 0, 0, 1'b0, 7, r, p);
    check("tp3_ge_pass", p, 1);

    do_load(0, 8'h00);
    do_load(1, 8'h81);
    do_op(2, 0, 1, 1, 2, 0, 1'b0, 0, r, p);
    check("tp4_asr", r, 8'hC0);
    do_op(2, 0, 1, 1, 1, 0, 1'b0, 0, r, p);
    check("tp4_lsr", r, 8'h40);
    do_op(2, 0, 1, 1, 3, 0, 1'b0, 0, r, p);
    check("tp4_ror", r, 8'hC0);
    do_op(2, 0, 1, 3, 0, 0, 1'b0, 0, r, p);
    check("tp4_lsl", r, 8'h08);

    // Same register as destination and both sources reads the old value
    do_load(2, 8'h21);
    do_op(2, 2, 2, 0, 0, 0, 1'b1, 0, r, p);
    check("same_reg", r, 8'h42);

    for (int k = 0; k < 40; k++) begin
      run_cmd(($urandom_range(0, 4) == 0), 8'($urandom), $urandom_range(0, NREGS - 1),
              $urandom_range(0, NREGS - 1), $urandom_range(0, NREGS - 1), $urandom_range(0, 7),
              $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom), 1'($urandom),
              ($urandom_range(0, 1) == 1) ? 0 : $urandom_range(0, 15), r, p);
    end

    // cmd_valid held high: accepts only every 4th edge
    nacc = 0;
    ndone = 0;
    ndouble = 0;
    prev_done = 1'b0;
    for (int i = 0; i < 4; i++) acc_e[i] = -1;
    drive(1'b1, 8'h11, 3, 0, 0, 0, 0, 0, 1'b1, 1'b0, 0);
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      cmd_valid = (i < 10);
      if (cmd_valid && cmd_ready) begin
        if (nacc < 4) acc_e[nacc] = i;
        nacc++;
      end
      if (i >= 1 && i <= 3) check("hold_ready_low", cmd_ready, 0);
      @(posedge clk); #1;
      if (done) begin
        ndone++;
        if (prev_done) ndouble++;
      end
      prev_done = done;
    end
    check("hold_nacc", nacc, 3);
    check("hold_acc0", acc_e[0], 0);
    check("hold_acc1", acc_e[1], 4);
    check("hold_acc2", acc_e[2], 8);
    check("hold_ndone", ndone, 3);
    check("hold_long_done", ndouble, 0);
    mregs[3] = 8'h11;
    check_regs("hold_reg");

    // Reset during EXEC aborts the command
    do_load(1, 8'h10);
    do_load(2, 8'h20);
    @(negedge clk);
    drive(1'b0, 8'd0, 0, 1, 2, 0, 0, 0, 1'b1, 1'b1, 0);
    cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    @(posedge clk); #1;
    check("rst_exec_busy", busy, 1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    for (int i = 0; i < NREGS; i++) mregs[i] = 0;
    mflags = 4'd0;
    check("abort_done", done, 0);
    check("abort_ready", cmd_ready, 1);
    check("abort_flags", flags, 0);
    check("abort_result", result, 0);
    check_regs("abort_reg");
    ndone = 0;
    repeat (4) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    check("abort_no_done", ndone, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alubarrel_seq.md
Name: alubarrel_seq

Overview:
Command-driven sequencer that owns the 8-bit ALUBarrel datapath. It adds a small register file and an NZCV flag register, so the ALU can execute conditional, ARM-style register-register operations.
- Accepts one command at a time over a valid/ready handshake.
- Sequences each command through read, execute and writeback.
- Pulses done with the result.

Parameters:
NREGS, 4, number of 8-bit general registers; register index width RA = $clog2(NREGS), minimum 1.

Ports:
clk  in  1  single clock, all state on rising edge
reset  in  1  synchronous, active-high; one clock, one reset, synchronous active-high
cmd_valid  in  1  command present
cmd_ready  out  1  controller can accept; high only in IDLE
cmd_load  in  1  1: write cmd_imm to rd, bypassing the ALU
cmd_imm  in  8  load immediate
cmd_rd  in  RA  destination register
cmd_rn  in  RA  first operand register
cmd_rm  in  RA  second operand register, passed through the barrel shifter
cmd_amt  in  3  shift amount
cmd_opbarrel  in  2  shift op: 00 LSL, 01 LSR, 10 ASR, 11 ROR
cmd_aluctl  in  2  ALU op: 00 ADD, 01 SUB, 10 AND, 11 OR
cmd_we  in  1  write result to rd
cmd_setflags  in  1  update the NZCV register
cmd_cond  in  4  condition, see Behaviour
done  out  1  one-cycle pulse in WB
result  out  8  ALU result or immediate; valid while done
cond_pass  out  1  condition outcome; valid while done
flags  out  4  committed NZCV as {N,Z,C,V}
busy  out  1  not IDLE
dbg_addr  in  RA  debug register select
dbg_data  out  8  combinational read of reg[dbg_addr]

Behaviour:
- FSM states and transitions:
  - IDLE: cmd_ready=1. cmd_valid&cmd_ready at an edge latches all cmd_* fields and goes to READ.
  - READ: latches reg[rn] and reg[rm] into operand registers; goes to EXEC.
  - EXEC: ALUBarrel is driven from the operand registers and the latched amt/opbarrel/aluctl. Registers result, NZCV and cond_pass; goes to WB.
  - WB: done=1, result and cond_pass valid. At the exiting edge:
    - if cond_pass&we, reg[rd] <= result;
    - if cond_pass&setflags&!load, flags <= new NZCV.
    - Then IDLE.
- Latency: command accepted at edge 0, done high between edges 2 and 3, commit at edge 3. cmd_ready returns the following cycle. Throughput is 1 command per 4 cycles.
- Condition is evaluated in EXEC against committed flags, i.e. those left by the previous command.
- Condition codes:
  - 0 AL; 1 EQ(Z); 2 NE(!Z)
  - 3 HS(C); 4 LO(!C); 5 HI(C&!Z); 6 LS(!C|Z)
  - 7 GE(N==V); 8 LT(N!=V); 9 GT(!Z&N==V); 10 LE(Z|N!=V)
  - 11-15 NV (never passes).
- Load: result=cmd_imm; condition and we still apply; flags are never touched.
- Flags: SUB sets C=1 when there is no borrow. V follows two's-complement overflow for ADD/SUB and is 0 for AND/OR.
- Register-file hazards:
  - No forwarding is needed: the write commits before the next accept.
  - rd==rn==rm in the same command reads old values.
- Input rules:
  - cmd_* fields are sampled only at the accept edge; changes while busy are ignored.
  - cmd_valid held high while busy produces no extra accept.
- Out-of-range indices when NREGS is not a power of two: reads return 0, writes are dropped.
- Reset values: state IDLE; all regs 0x00; flags 0000; done 0; result 0x00; cond_pass 0; busy 0. cmd_ready is 1 in the cycle after reset deasserts.
- Reset in any state aborts the command: no register or flag commit, no done.

Decomposition:
- Package alubarrel_seq_pkg holds:
  - state enum (IDLE, READ, EXEC, WB);
  - cond_e enum (AL..LE, NV);
  - ALU op constants (ADD, SUB, AND, OR);
  - shift op constants (LSL, LSR, ASR, ROR).
- Sub-module seq_cond_check: combinational, (cond_e, NZCV) -> pass. Instantiated once in EXEC.
- ALUBarrel is instantiated unchanged.

Test Plan:
- Reset, then LOAD R1=0x05 and LOAD R2=0x03, then SUB R0=R1-(R2 LSL 0), setflags, AL -> result 0x02, flags 0010, R0=0x02, done at the 3rd cycle after accept.
- SUB R3=R2-R1, setflags -> 0xFE, flags 1000; next ADD R3 cond HS -> cond_pass=0, R3 stays 0xFE, flags unchanged.
- LOAD R1=0x7F, R2=0x01; ADD setflags -> 0x80, flags 1001; next command cond LT (N!=V) -> pass=0; cond GE -> pass=1.
- R0=0x00, R1=0x81; ADD R0,(R1 ASR 1) -> 0xC0; LSR 1 -> 0x40; ROR 1 -> 0xC0; LSL 3 -> 0x08.
- cmd_valid held high for 10 cycles with one command -> cmd_ready low in READ/EXEC/WB. Exactly 3 accepts at edges 0, 4 and 8 (one per 4 cycles, no extra accepts); done pulses exactly 1 cycle each.
- Assert reset during EXEC of ADD R0 -> no done pulse; R0=0x00, flags 0000; cmd_ready=1 in the cycle after reset deasserts.
